dff_write_arbiter: RTL and testbench

Round-robin write arbiter in front of a shared W-bit D-flip-flop register. Up to N requesters compete each cycle to load the shared register; one winner is granted per cycle, its data is captured on the next rising edge, and a synchronous clear path empties the register. Sits between multiple producer blocks and a single storage flop bank that all of them read through `q`.

---
 rtl/dff_write_arbiter.sv | 100 ++++++++++
 tb/tb_dff_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter feeding one shared W-bit register. One requester wins per cycle.
// Define DFF_ARB_LOCK_EN to build in the ownership lock and to add the lock/locked ports.
module dff_write_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         wdata,
    input  logic                   clr,
`ifdef DFF_ARB_LOCK_EN
    input  logic [N-1:0]           lock,
    output logic                   locked,
`endif
    output logic [N-1:0]           gnt,
    output logic [W-1:0]           q,
    output logic                   valid,
    output logic [$clog2(N)-1:0]   last_id
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win_id;
    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] idx;
    logic          win_vld;
`ifdef DFF_ARB_LOCK_EN
    logic [IW-1:0] owner;
`endif

    // Scan upward from ptr with wrap-around; the first request found wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
`ifdef DFF_ARB_LOCK_EN
        // While locked, only the owner can be granted; everyone else waits.
        if (locked) begin
            win_vld = req[owner];
            win_id  = owner;
        end
`endif
        if (reset || clr)
            win_vld = 1'b0;
        gnt = '0;
        if (win_vld)
            gnt[win_id] = 1'b1;
    end

    assign nxt_ptr = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            valid   <= 1'b0;
            last_id <= '0;
            ptr     <= '0;
`ifdef DFF_ARB_LOCK_EN
            locked  <= 1'b0;
            owner   <= '0;
`endif
        end else if (clr) begin
            // Clear empties the register but leaves the pointer and any lock as they are.
            q     <= '0;
            valid <= 1'b0;
        end else begin
            if (win_vld) begin
                q       <= wdata[win_id*W +: W];
                valid   <= 1'b1;
                last_id <= win_id;
            end
`ifdef DFF_ARB_LOCK_EN
            if (locked) begin
                if (!req[owner] || !lock[owner]) begin
                    locked <= 1'b0;
                    if (req[owner])
                        ptr <= nxt_ptr;
                end
            end else if (win_vld) begin
                ptr <= nxt_ptr;
                if (lock[win_id]) begin
                    locked <= 1'b1;
                    owner  <= win_id;
                end
            end
`else
            if (win_vld)
                ptr <= nxt_ptr;
`endif
        end
    end
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed testbench for dff_write_arbiter (N=4, W=8) using hand-computed expectations.
module tb_dff_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        valid;
    logic [1:0]  last_id;
`ifdef DFF_ARB_LOCK_EN
    logic [3:0]  lock;
    logic        locked;
`endif

    int checks   = 0;
    int failures = 0;

    dff_write_arbiter #(.N(4), .W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .clr     (clr),
`ifdef DFF_ARB_LOCK_EN
        .lock    (lock),
        .locked  (locked),
`endif
        .gnt     (gnt),
        .q       (q),
        .valid   (valid),
        .last_id (last_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        wdata = 32'h44332211;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt2 got=%b exp=0000", gnt); end
        checks++;
        if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (last_id !== 2'd0) begin failures++; $display("FAIL reset_last_id got=%0d exp=0", last_id); end
`ifdef DFF_ARB_LOCK_EN
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
`endif
        reset = 1'b0;
        req   = 4'b0000;
    endtask

    // Only requester 2 has defined data; X on the others must not reach q.
    task automatic test_single();
        req   = 4'b0100;
        wdata = {8'hxx, 8'hA5, 8'hxx, 8'hxx};
        #1;
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (q !== 8'hA5) begin failures++; $display("FAIL single_q got=%h exp=a5", q); end
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid); end
        checks++;
        if (last_id !== 2'd2) begin failures++; $display("FAIL single_last_id got=%0d exp=2", last_id); end
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL idle_gnt got=%b exp=0000", gnt); end
        tick();
        checks++;
        if (q !== 8'hA5 || valid !== 1'b1 || last_id !== 2'd2) begin
            failures++;
            $display("FAIL idle_hold got=q%h v%b id%0d exp=qa5 v1 id2", q, valid, last_id);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [5];
        logic [1:0] exp_i [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req   = 4'b1111;
        wdata = 32'h13121110;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (gnt !== exp_g[c]) begin failures++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", c, gnt, exp_g[c]); end
            tick();
            checks++;
            if (last_id !== exp_i[c]) begin failures++; $display("FAIL fair_last_id[%0d] got=%0d exp=%0d", c, last_id, exp_i[c]); end
            checks++;
            if (q !== 8'h10 + {6'd0, exp_i[c]}) begin failures++; $display("FAIL fair_q[%0d] got=%h exp=%h", c, q, 8'h10 + {6'd0, exp_i[c]}); end
        end
        req = 4'b0000;
    endtask

    // Pointer sits at 1 after the fairness run; clear must not move it.
    task automatic test_clear();
        req   = 4'b0010;
        clr   = 1'b1;
        wdata = 32'hDDCCBBAA;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL clr_gnt got=%b exp=0000", gnt); end
        tick();
        clr = 1'b0;
        req = 4'b1111;
        #1;
        checks++;
        if (q !== 8'h00 || valid !== 1'b0) begin failures++; $display("FAIL clr_q_valid got=q%h v%b exp=q00 v0", q, valid); end
        checks++;
        if (last_id !== 2'd0) begin failures++; $display("FAIL clr_last_id got=%0d exp=0", last_id); end
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL clr_ptr_gnt got=%b exp=0010", gnt); end
        tick();
        checks++;
        if (q !== 8'hBB || valid !== 1'b1 || last_id !== 2'd1) begin
            failures++;
            $display("FAIL clr_rewrite got=q%h v%b id%0d exp=qbb v1 id1", q, valid, last_id);
        end
        req = 4'b0000;
    endtask

    // ptr=2: req 1001 goes to 3, then wraps so 0 wins next.
    task automatic test_wrap();
        req   = 4'b1001;
        wdata = 32'h40302010;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL wrap_gnt3 got=%b exp=1000", gnt); end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt0 got=%b exp=0001", gnt); end
        checks++;
        if (q !== 8'h40 || last_id !== 2'd3) begin failures++; $display("FAIL wrap_q3 got=q%h id%0d exp=q40 id3", q, last_id); end
        tick();
        checks++;
        if (q !== 8'h10 || last_id !== 2'd0) begin failures++; $display("FAIL wrap_q0 got=q%h id%0d exp=q10 id0", q, last_id); end
        req = 4'b0000;
    endtask

    // ptr=1 with requesters 0 and 1 both asserted: strict alternation 1,0,1.
    task automatic test_back_to_back();
        logic [3:0] exp_g [3];
        logic [7:0] exp_q [3];
        exp_g = '{4'b0010, 4'b0001, 4'b0010};
        exp_q = '{8'h5B, 8'h5A, 8'h5B};
        req   = 4'b0011;
        wdata = {8'hxx, 8'hxx, 8'h5B, 8'h5A};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== exp_g[c]) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", c, gnt, exp_g[c]); end
            tick();
            checks++;
            if (q !== exp_q[c]) begin failures++; $display("FAIL b2b_q[%0d] got=%h exp=%h", c, q, exp_q[c]); end
        end
        req = 4'b0000;
    endtask

    // reset wins over clr and requests, and restores ptr to 0.
    task automatic test_reset_priority();
        reset = 1'b1;
        clr   = 1'b1;
        req   = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL rstpri_gnt got=%b exp=0000", gnt); end
        tick();
        reset = 1'b0;
        clr   = 1'b0;
        req   = 4'b1010;
        #1;
        checks++;
        if (last_id !== 2'd0 || valid !== 1'b0) begin failures++; $display("FAIL rstpri_state got=id%0d v%b exp=id0 v0", last_id, valid); end
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL rstpri_ptr got=%b exp=0010", gnt); end
        tick();
        req = 4'b0000;
    endtask

`ifdef DFF_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req   = 4'b0011;
        lock  = 4'b0001;
        wdata = 32'h000000E1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_gnt[%0d] got=%b exp=0001", c, gnt); end
            tick();
            checks++;
            if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked[%0d] got=%b exp=1", c, locked); end
        end
        lock = 4'b0000;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_final_gnt got=%b exp=0001", gnt); end
        tick();
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_release got=%b exp=0", locked); end
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL lock_next_gnt got=%b exp=0010", gnt); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_lock_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        tick();
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lockrst_set got=%b exp=1", locked); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lock  = 4'b0000;
        req   = 4'b0010;
        #1;
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lockrst_locked got=%b exp=0", locked); end
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL lockrst_gnt got=%b exp=0010", gnt); end
        tick();
        req = 4'b0000;
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        wdata = '0;
        clr   = 1'b0;
`ifdef DFF_ARB_LOCK_EN
        lock  = 4'b0000;
`endif
        tick();
        test_reset();
        test_single();
        test_fairness();
        test_clear();
        test_wrap();
        test_back_to_back();
        test_reset_priority();
`ifdef DFF_ARB_LOCK_EN
        test_lock();
        test_lock_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
